// File: rtl/async_queue_pkg.sv
// Shared helpers for the clock-crossing queue: Gray conversion and parameter range limits.
package async_queue_pkg;

    localparam int unsigned SYNC_MIN      = 2;
    localparam int unsigned SYNC_MAX      = 4;
    localparam int unsigned LOG_DEPTH_MAX = 6;
    localparam int unsigned PTR_W_MAX     = LOG_DEPTH_MAX + 1;

    typedef logic [PTR_W_MAX-1:0] ptr_t;

    // Narrower pointers are zero-extended into ptr_t; leading zeros leave both conversions intact.
    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic params_legal(input int unsigned log_depth, input int unsigned sync);
        return (log_depth <= LOG_DEPTH_MAX) && (sync >= SYNC_MIN) && (sync <= SYNC_MAX);
    endfunction

endpackage

// File: rtl/async_queue_sink_param_sync.sv
// Multi-flop synchroniser for one crossing bus; every stage clears on reset.
module async_sync_chain #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_queue_sink_param.sv
// Sink (dequeue) half of the clock-crossing queue with source/sink presence handshake.
// Define ASYNC_QUEUE_SINK_OCCUPANCY_EN to add the registered occupancy output.
module async_queue_sink_param
    import async_queue_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LOG_DEPTH = 3,
    parameter int unsigned SYNC      = 3
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [(WIDTH << LOG_DEPTH)-1:0]    mem,
    input  logic [LOG_DEPTH:0]                 widx_gray,
    output logic [LOG_DEPTH:0]                 ridx_gray,
    input  logic                               source_valid,
    output logic                               sink_valid,
    output logic                               deq_valid,
    input  logic                               deq_ready,
`ifdef ASYNC_QUEUE_SINK_OCCUPANCY_EN
    output logic [LOG_DEPTH:0]                 occupancy,
`endif
    output logic [WIDTH-1:0]                   deq_bits
);

    localparam int unsigned Depth = 1 << LOG_DEPTH;
    localparam int unsigned PtrW  = LOG_DEPTH + 1;
    localparam int unsigned IdxW  = (LOG_DEPTH > 0) ? LOG_DEPTH : 1;

    if (!params_legal(LOG_DEPTH, SYNC)) begin : g_bad_params
        $error("async_queue_sink_param: LOG_DEPTH must be 0..6 and SYNC 2..4");
    end

    logic [PtrW-1:0] widx_s;
    logic            source_ready;

    async_sync_chain #(
        .WIDTH (PtrW),
        .STAGES(SYNC)
    ) u_widx_sync (
        .clk_i (clock),
        .rst_ni(reset_n),
        .d_i   (widx_gray),
        .q_o   (widx_s)
    );

    async_sync_chain #(
        .WIDTH (1),
        .STAGES(SYNC)
    ) u_valid_sync (
        .clk_i (clock),
        .rst_ni(reset_n),
        .d_i   (source_valid),
        .q_o   (source_ready)
    );

    logic [WIDTH-1:0] entries [Depth];
    for (genvar i = 0; i < Depth; i++) begin : g_entry
        assign entries[i] = mem[i*WIDTH +: WIDTH];
    end

    logic [PtrW-1:0]  ridx_bin_d, ridx_bin_q;
    logic [PtrW-1:0]  ridx_gray_d, ridx_gray_q;
    logic             deq_valid_d, deq_valid_q;
    logic [WIDTH-1:0] deq_bits_d, deq_bits_q;
    logic             sink_valid_d, sink_valid_q;

    logic             fire;
    logic             load;
    logic [PtrW-1:0]  ridx_next;
    logic [PtrW-1:0]  ridx_gray_next;
    logic [IdxW-1:0]  rd_idx;

    // Losing the source collapses the pointer to zero, discarding queued entries and any fire.
    always_comb begin
        fire           = deq_valid_q & deq_ready;
        ridx_next      = source_ready ? ridx_bin_q + PtrW'(fire) : '0;
        ridx_gray_next = PtrW'(bin2gray(ptr_t'(ridx_next)));
        load           = source_ready & (ridx_gray_next != widx_s);
        ridx_bin_d     = ridx_next;
        ridx_gray_d    = ridx_gray_next;
        deq_valid_d    = load;
        sink_valid_d   = 1'b1;
    end

    if (LOG_DEPTH == 0) begin : g_idx_single
        assign rd_idx = '0;
    end else begin : g_idx
        assign rd_idx = ridx_next[IdxW-1:0];
    end

    always_comb begin
        deq_bits_d = load ? entries[rd_idx] : deq_bits_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ridx_bin_q   <= '0;
            ridx_gray_q  <= '0;
            deq_valid_q  <= 1'b0;
            deq_bits_q   <= '0;
            sink_valid_q <= 1'b0;
        end else begin
            ridx_bin_q   <= ridx_bin_d;
            ridx_gray_q  <= ridx_gray_d;
            deq_valid_q  <= deq_valid_d;
            deq_bits_q   <= deq_bits_d;
            sink_valid_q <= sink_valid_d;
        end
    end

    assign ridx_gray  = ridx_gray_q;
    assign deq_valid  = deq_valid_q;
    assign deq_bits   = deq_bits_q;
    assign sink_valid = sink_valid_q;

`ifdef ASYNC_QUEUE_SINK_OCCUPANCY_EN
    logic [PtrW-1:0] occupancy_d, occupancy_q;

    // Stale widx_s can only under-count, so the reported value never exceeds the true fill.
    always_comb begin
        occupancy_d = source_ready ? PtrW'(gray2bin(ptr_t'(widx_s))) - ridx_next : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    assign occupancy = occupancy_q;
`endif

endmodule

// File: tb/tb_async_queue_sink_param.sv
// Self-checking bench for async_queue_sink_param: the bench plays the source and scoreboards dequeues.
module tb_async_queue_sink_param;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned LOG_DEPTH = 3;
    localparam int unsigned SYNC      = 3;
    localparam int unsigned DEPTH     = 8;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic [DEPTH*WIDTH-1:0] mem;
    logic [LOG_DEPTH:0]     widx_gray;
    logic [LOG_DEPTH:0]     ridx_gray;
    logic                   source_valid;
    logic                   sink_valid;
    logic                   deq_valid;
    logic                   deq_ready;
    logic [WIDTH-1:0]       deq_bits;
`ifdef ASYNC_QUEUE_SINK_OCCUPANCY_EN
    logic [LOG_DEPTH:0]     occupancy;
`endif

    always #5 clock = ~clock;

    async_queue_sink_param #(
        .WIDTH    (WIDTH),
        .LOG_DEPTH(LOG_DEPTH),
        .SYNC     (SYNC)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mem         (mem),
        .widx_gray   (widx_gray),
        .ridx_gray   (ridx_gray),
        .source_valid(source_valid),
        .sink_valid  (sink_valid),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
`ifdef ASYNC_QUEUE_SINK_OCCUPANCY_EN
        .occupancy   (occupancy),
`endif
        .deq_bits    (deq_bits)
    );

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [WIDTH-1:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LOG_DEPTH:0] to_gray(input int n);
        logic [LOG_DEPTH:0] b;
        b = n[LOG_DEPTH:0];
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_mem(input logic [WIDTH-1:0] d);
        mem[(wr_cnt % DEPTH)*WIDTH +: WIDTH] = d;
        exp_q.push_back(d);
        wr_cnt++;
    endtask

    task automatic publish();
        widx_gray = to_gray(wr_cnt);
    endtask

    // Called before the edge: a handshake seen now retires the head entry at that edge.
    task automatic sb_step();
        if (deq_valid && deq_ready) begin
            check_eq("sb_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_eq("sb_data", deq_bits, exp_q.pop_front());
            rd_cnt++;
        end
    endtask

    task automatic fire_one();
        deq_ready = 1'b1;
        check_eq("fire_valid", deq_valid, 1);
        sb_step();
        tick();
        deq_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        source_valid = 1'b0;
        deq_ready    = 1'b0;
        widx_gray    = '0;
        mem          = '0;
        wr_cnt       = 0;
        rd_cnt       = 0;
        exp_q.delete();
        repeat (3) tick();
        check_eq("rst_ridx", ridx_gray, 0);
        check_eq("rst_valid", deq_valid, 0);
        check_eq("rst_bits", deq_bits, 0);
        check_eq("rst_sink_valid", sink_valid, 0);
`ifdef ASYNC_QUEUE_SINK_OCCUPANCY_EN
        check_eq("rst_occupancy", occupancy, 0);
`endif
        reset_n      = 1'b1;
        source_valid = 1'b1;
        tick();
        check_eq("sink_valid_up", sink_valid, 1);
        repeat (SYNC + 2) begin
            tick();
            check_eq("idle_valid", deq_valid, 0);
            check_eq("idle_ridx", ridx_gray, 0);
        end
    endtask

    initial begin
        int first;
        int last;
        int fires;

        do_reset();

        // Single entry: latency and hold under back-pressure.
        write_mem(16'hA5A5);
        publish();
        for (int i = 1; i <= SYNC; i++) begin
            tick();
            check_eq("lat_early", deq_valid, 0);
        end
        tick();
        check_eq("lat_valid", deq_valid, 1);
        check_eq("lat_bits", deq_bits, 16'hA5A5);
        repeat (3) begin
            tick();
            check_eq("hold_valid", deq_valid, 1);
            check_eq("hold_bits", deq_bits, 16'hA5A5);
        end
        deq_ready = 1'b1;
        sb_step();
        tick();
        deq_ready = 1'b0;
        check_eq("single_ridx", ridx_gray, 1);
        check_eq("single_empty", deq_valid, 0);

        // Full queue drained back to back.
        do_reset();
        for (int i = 0; i < DEPTH; i++) write_mem(16'(i));
        publish();
        repeat (SYNC + 3) tick();
`ifdef ASYNC_QUEUE_SINK_OCCUPANCY_EN
        check_eq("occ_full", occupancy, DEPTH);
`endif
        deq_ready = 1'b1;
        first = -1;
        last  = -1;
        fires = 0;
        for (int c = 0; c < 20 && rd_cnt < DEPTH; c++) begin
            if (deq_valid) begin
                if (first < 0) first = c;
                last = c;
                fires++;
            end
            sb_step();
            tick();
        end
        deq_ready = 1'b0;
        check_eq("burst_count", fires, DEPTH);
        check_eq("burst_span", last - first + 1, DEPTH);
        check_eq("burst_ridx", ridx_gray, 4'hC);
        check_eq("burst_empty", deq_valid, 0);

        // Random stream across several pointer wraps.
        for (int c = 0; c < 2000 && rd_cnt < 48; c++) begin
            deq_ready = ($urandom_range(0, 3) != 0);
            sb_step();
            if (wr_cnt < 48 && (wr_cnt - rd_cnt) < DEPTH && $urandom_range(0, 3) != 0) begin
                write_mem(16'($urandom));
                publish();
            end
            tick();
        end
        deq_ready = 1'b0;
        check_eq("stream_count", rd_cnt, 48);
        check_eq("stream_left", exp_q.size(), 0);
        check_eq("stream_ridx", ridx_gray, to_gray(48));
        tick();
        check_eq("stream_empty", deq_valid, 0);

        // Partial drain, then source disappears with entries pending.
        for (int i = 0; i < 7; i++) write_mem(16'h5000 + 16'(i));
        publish();
        repeat (SYNC + 3) tick();
        fire_one();
`ifdef ASYNC_QUEUE_SINK_OCCUPANCY_EN
        check_eq("occ_six", occupancy, 6);
`endif
        fire_one();
        fire_one();
`ifdef ASYNC_QUEUE_SINK_OCCUPANCY_EN
        check_eq("occ_four", occupancy, 4);
`endif
        write_mem(16'h5007);
        publish();
        repeat (SYNC + 2) tick();
        check_eq("drop_pre_valid", deq_valid, 1);
        check_eq("drop_pre_ridx", ridx_gray, to_gray(rd_cnt));
        source_valid = 1'b0;
        for (int i = 1; i <= SYNC; i++) begin
            tick();
            check_eq("drop_hold", deq_valid, 1);
        end
        tick();
        check_eq("drop_valid", deq_valid, 0);
        check_eq("drop_ridx", ridx_gray, 0);

        exp_q.delete();
        wr_cnt       = 0;
        rd_cnt       = 0;
        mem          = '0;
        widx_gray    = '0;
        source_valid = 1'b1;
        repeat (SYNC + 3) begin
            tick();
            check_eq("restore_valid", deq_valid, 0);
            check_eq("restore_ridx", ridx_gray, 0);
        end

        write_mem(16'h1234);
        publish();
        deq_ready = 1'b1;
        for (int c = 0; c < 12 && rd_cnt < 1; c++) begin
            sb_step();
            tick();
        end
        deq_ready = 1'b0;
        check_eq("resume_count", rd_cnt, 1);

        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
